// File: rtl/t6507lp_alu_sched_pkg.sv
// rtl/t6507lp_alu_sched_pkg.sv - opcodes, status bit indices and scheduler states for the ALU scheduler
package t6507lp_alu_sched_pkg;

    localparam logic [7:0] NOP     = 8'hEA;
    localparam logic [7:0] LDA_IMM = 8'hA9;
    localparam logic [7:0] ADC_IMM = 8'h69;
    localparam logic [7:0] AND_IMM = 8'h29;
    localparam logic [7:0] ORA_IMM = 8'h09;
    localparam logic [7:0] EOR_IMM = 8'h49;

    localparam int STATUS_C = 0;
    localparam int STATUS_Z = 1;
    localparam int STATUS_I = 2;
    localparam int STATUS_D = 3;
    localparam int STATUS_B = 4;
    localparam int STATUS_V = 6;
    localparam int STATUS_N = 7;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_DONE  = 2'd3
    } sched_state_t;

    // WAIT ends when the counter reaches zero, so it starts one below the latency.
    function automatic logic [1:0] sched_wait_load(input int latency);
        return 2'(latency - 1);
    endfunction

endpackage

// File: rtl/t6507lp_alu_sched_if.sv
// rtl/t6507lp_alu_sched_if.sv - requester and ALU pin bundle of the ALU scheduler
interface t6507lp_alu_sched_if;
    logic       req0_i;
    logic       req1_i;
    logic [7:0] op0_i;
    logic [7:0] op1_i;
    logic [7:0] a0_i;
    logic [7:0] a1_i;
    logic       gnt0_o;
    logic       gnt1_o;
    logic       done0_o;
    logic       done1_o;
    logic       owner_o;
    logic       busy_o;
    logic [7:0] result_o;
    logic [7:0] status_o;
    logic       alu_enable_o;
    logic [7:0] alu_opcode_o;
    logic [7:0] alu_a_o;
    logic [7:0] alu_result_i;
    logic [7:0] alu_status_i;

    modport slave (
        input  req0_i, req1_i, op0_i, op1_i, a0_i, a1_i, alu_result_i, alu_status_i,
        output gnt0_o, gnt1_o, done0_o, done1_o, owner_o, busy_o, result_o, status_o,
        output alu_enable_o, alu_opcode_o, alu_a_o
    );

    modport master (
        output req0_i, req1_i, op0_i, op1_i, a0_i, a1_i, alu_result_i, alu_status_i,
        input  gnt0_o, gnt1_o, done0_o, done1_o, owner_o, busy_o, result_o, status_o,
        input  alu_enable_o, alu_opcode_o, alu_a_o
    );
endinterface

// File: rtl/t6507lp_alu_sched_pick.sv
// rtl/t6507lp_alu_sched_pick.sv - two-way request picker; ALU_SCHED_ROUND_ROBIN_EN selects round robin over fixed priority
module t6507lp_alu_sched_pick
    import t6507lp_alu_sched_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef ALU_SCHED_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic winner,
    output logic valid
);
    assign valid = req0 | req1;

`ifdef ALU_SCHED_ROUND_ROBIN_EN
    // On a tie the requester not served last wins; a lone request always wins.
    assign winner = (req0 & req1) ? ~last_owner : req1;
`else
    assign winner = ~req0 & req1;
`endif
endmodule

// File: rtl/t6507lp_alu_sched.sv
// rtl/t6507lp_alu_sched.sv - shares one T6507LP ALU between two requesters; ALU_SCHED_ROUND_ROBIN_EN enables round-robin ties
module t6507lp_alu_sched
    import t6507lp_alu_sched_pkg::*;
#(
    parameter int         ALU_LATENCY = 1,
    parameter logic [7:0] IDLE_OPCODE = NOP
) (
    input  logic               clk_i,
    input  logic               n_rst_i,
    t6507lp_alu_sched_if.slave bus
);
    localparam logic [1:0] WAIT_LOAD = sched_wait_load(ALU_LATENCY);

    sched_state_t state;
    logic [1:0]   wait_cnt;
    logic         pick_winner;
    logic         pick_valid;

`ifdef ALU_SCHED_ROUND_ROBIN_EN
    // rr_ptr names the requester preferred on the next tie.
    logic rr_ptr;
`endif

    t6507lp_alu_sched_pick u_pick (
        .req0       (bus.req0_i),
        .req1       (bus.req1_i),
`ifdef ALU_SCHED_ROUND_ROBIN_EN
        .last_owner (~rr_ptr),
`endif
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state            <= SCHED_IDLE;
            wait_cnt         <= 2'd0;
            bus.gnt0_o       <= 1'b0;
            bus.gnt1_o       <= 1'b0;
            bus.done0_o      <= 1'b0;
            bus.done1_o      <= 1'b0;
            bus.owner_o      <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.result_o     <= 8'h00;
            bus.status_o     <= 8'h00;
            bus.alu_enable_o <= 1'b0;
            bus.alu_opcode_o <= IDLE_OPCODE;
            bus.alu_a_o      <= 8'h00;
`ifdef ALU_SCHED_ROUND_ROBIN_EN
            rr_ptr           <= 1'b0;
`endif
        end else begin
            bus.gnt0_o       <= 1'b0;
            bus.gnt1_o       <= 1'b0;
            bus.done0_o      <= 1'b0;
            bus.done1_o      <= 1'b0;
            bus.alu_enable_o <= 1'b0;
            case (state)
                SCHED_IDLE: begin
                    if (pick_valid) begin
                        state            <= SCHED_ISSUE;
                        wait_cnt         <= WAIT_LOAD;
                        bus.owner_o      <= pick_winner;
                        bus.gnt0_o       <= ~pick_winner;
                        bus.gnt1_o       <= pick_winner;
                        bus.busy_o       <= 1'b1;
                        bus.alu_enable_o <= 1'b1;
                        bus.alu_opcode_o <= pick_winner ? bus.op1_i : bus.op0_i;
                        bus.alu_a_o      <= pick_winner ? bus.a1_i : bus.a0_i;
`ifdef ALU_SCHED_ROUND_ROBIN_EN
                        rr_ptr           <= ~pick_winner;
`endif
                    end
                end
                SCHED_ISSUE: begin
                    state <= SCHED_WAIT;
                end
                SCHED_WAIT: begin
                    // Capture on the last WAIT cycle so done lines up with the stored result.
                    if (wait_cnt == 2'd0) begin
                        state        <= SCHED_DONE;
                        bus.result_o <= bus.alu_result_i;
                        bus.status_o <= bus.alu_status_i;
                        bus.done0_o  <= ~bus.owner_o;
                        bus.done1_o  <= bus.owner_o;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                SCHED_DONE: begin
                    state            <= SCHED_IDLE;
                    bus.busy_o       <= 1'b0;
                    bus.alu_opcode_o <= IDLE_OPCODE;
                end
                default: begin
                    state <= SCHED_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_t6507lp_alu_sched.sv
// tb/tb_t6507lp_alu_sched.sv - self-checking bench for t6507lp_alu_sched (latency 1 and 3 instances)
module tb_t6507lp_alu_sched;
    import t6507lp_alu_sched_pkg::*;

    localparam int NR = 400;

    typedef struct packed {
        logic [7:0] acc;
        logic       c;
        logic       v;
        logic [7:0] res;
        logic [7:0] st;
    } alu_out_t;

    typedef struct packed {
        logic       sel;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] res;
        logic [7:0] st;
    } vec_t;

    typedef struct packed {
        logic       gnt0, gnt1, done0, done1, busy, en, set_own, own, set_res, set_opc;
        logic [7:0] res, st, opc, a;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    t6507lp_alu_sched_if if1();
    t6507lp_alu_sched_if if3();

    t6507lp_alu_sched #(.ALU_LATENCY(1), .IDLE_OPCODE(NOP)) dut1 (
        .clk_i(clk), .n_rst_i(n_rst), .bus(if1.slave));
    t6507lp_alu_sched #(.ALU_LATENCY(3), .IDLE_OPCODE(NOP)) dut3 (
        .clk_i(clk), .n_rst_i(n_rst), .bus(if3.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural 6502 immediate-mode ALU; status layout N V 1 B D I Z C.
    function automatic alu_out_t alu_ref(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] acc, input logic c, input logic v);
        alu_out_t   o;
        logic [8:0] sum;
        o.acc = acc; o.c = c; o.v = v;
        case (op)
            LDA_IMM: o.acc = a;
            ADC_IMM: begin
                sum   = {1'b0, acc} + {1'b0, a} + {8'h00, c};
                o.acc = sum[7:0];
                o.c   = sum[8];
                o.v   = (acc[7] == a[7]) && (sum[7] != acc[7]);
            end
            AND_IMM: o.acc = acc & a;
            ORA_IMM: o.acc = acc | a;
            EOR_IMM: o.acc = acc ^ a;
            default: ;
        endcase
        o.res = o.acc;
        o.st = 8'h20;
        o.st[STATUS_N] = o.acc[7];
        o.st[STATUS_V] = o.v;
        o.st[STATUS_Z] = (o.acc == 8'h00);
        o.st[STATUS_C] = o.c;
        return o;
    endfunction

    // ALU stand-ins: result valid ALU_LATENCY cycles after the enable edge, junk otherwise.
    logic [7:0] acc1, acc3;
    logic       c1, v1, c3, v3;
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];
    alu_out_t   ar1, ar3;
    always_comb ar1 = alu_ref(if1.alu_opcode_o, if1.alu_a_o, acc1, c1, v1);
    always_comb ar3 = alu_ref(if3.alu_opcode_o, if3.alu_a_o, acc3, c3, v3);

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc1 <= 8'h00; c1 <= 1'b0; v1 <= 1'b0; pipe1 <= 16'h0000;
        end else if (if1.alu_enable_o) begin
            acc1 <= ar1.acc; c1 <= ar1.c; v1 <= ar1.v; pipe1 <= {ar1.res, ar1.st};
        end else begin
            pipe1 <= 16'($urandom);
        end
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc3 <= 8'h00; c3 <= 1'b0; v3 <= 1'b0;
            pipe3[0] <= 16'h0000; pipe3[1] <= 16'h0000; pipe3[2] <= 16'h0000;
        end else begin
            if (if3.alu_enable_o) begin
                acc3 <= ar3.acc; c3 <= ar3.c; v3 <= ar3.v; pipe3[0] <= {ar3.res, ar3.st};
            end else begin
                pipe3[0] <= 16'($urandom);
            end
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end

    assign if1.alu_result_i = pipe1[15:8];
    assign if1.alu_status_i = pipe1[7:0];
    assign if3.alu_result_i = pipe3[2][15:8];
    assign if3.alu_status_i = pipe3[2][7:0];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt0"},  8'(if1.gnt0_o), 8'h00);
        chk({tag, "_gnt1"},  8'(if1.gnt1_o), 8'h00);
        chk({tag, "_done0"}, 8'(if1.done0_o), 8'h00);
        chk({tag, "_done1"}, 8'(if1.done1_o), 8'h00);
        chk({tag, "_busy"},  8'(if1.busy_o), 8'h00);
        chk({tag, "_owner"}, 8'(if1.owner_o), 8'h00);
        chk({tag, "_en"},    8'(if1.alu_enable_o), 8'h00);
        chk({tag, "_opc"},   if1.alu_opcode_o, 8'hEA);
        chk({tag, "_a"},     if1.alu_a_o, 8'h00);
        chk({tag, "_res"},   if1.result_o, 8'h00);
        chk({tag, "_st"},    if1.status_o, 8'h00);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        tick1();
        if (v.sel) begin
            if1.req1_i = 1'b1; if1.op1_i = v.op; if1.a1_i = v.a;
        end else begin
            if1.req0_i = 1'b1; if1.op0_i = v.op; if1.a0_i = v.a;
        end
        tick1();
        chk({tag, "_gnt0"}, 8'(if1.gnt0_o), 8'(!v.sel));
        chk({tag, "_gnt1"}, 8'(if1.gnt1_o), 8'(v.sel));
        chk({tag, "_en"},   8'(if1.alu_enable_o), 8'h01);
        chk({tag, "_opc"},  if1.alu_opcode_o, v.op);
        chk({tag, "_a"},    if1.alu_a_o, v.a);
        tick1();
        if1.req0_i = 1'b0; if1.req1_i = 1'b0;
        chk({tag, "_early_done"}, 8'(if1.done0_o | if1.done1_o), 8'h00);
        chk({tag, "_wait_en"},    8'(if1.alu_enable_o), 8'h00);
        tick1();
        chk({tag, "_done0"}, 8'(if1.done0_o), 8'(!v.sel));
        chk({tag, "_done1"}, 8'(if1.done1_o), 8'(v.sel));
        chk({tag, "_res"},   if1.result_o, v.res);
        chk({tag, "_st"},    if1.status_o, v.st);
        chk({tag, "_owner"}, 8'(if1.owner_o), 8'(v.sel));
        chk({tag, "_busy"},  8'(if1.busy_o), 8'h01);
        tick1();
        chk({tag, "_idle_busy"}, 8'(if1.busy_o), 8'h00);
        chk({tag, "_idle_opc"},  if1.alu_opcode_o, NOP);
    endtask

    task automatic lat3_op(input logic sel, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] prev, input logic [7:0] res, input logic [7:0] st,
                           input string tag);
        tick1();
        if (sel) begin
            if3.req1_i = 1'b1; if3.op1_i = op; if3.a1_i = a;
        end else begin
            if3.req0_i = 1'b1; if3.op0_i = op; if3.a0_i = a;
        end
        tick1();
        chk({tag, "_gnt"}, 8'(sel ? if3.gnt1_o : if3.gnt0_o), 8'h01);
        chk({tag, "_opc"}, if3.alu_opcode_o, op);
        tick1();
        if3.req0_i = 1'b0; if3.req1_i = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            chk($sformatf("%s_nodone_n%0d", tag, k), 8'(if3.done0_o | if3.done1_o), 8'h00);
            chk($sformatf("%s_held_n%0d", tag, k), if3.result_o, prev);
            chk($sformatf("%s_busy_n%0d", tag, k), 8'(if3.busy_o), 8'h01);
            tick1();
        end
        chk({tag, "_done"},  8'(sel ? if3.done1_o : if3.done0_o), 8'h01);
        chk({tag, "_res"},   if3.result_o, res);
        chk({tag, "_st"},    if3.status_o, st);
        chk({tag, "_owner"}, 8'(if3.owner_o), 8'(sel));
        tick1();
        chk({tag, "_idle_busy"}, 8'(if3.busy_o), 8'h00);
        chk({tag, "_idle_opc"},  if3.alu_opcode_o, NOP);
        repeat (2) begin
            tick1();
            chk({tag, "_keep_res"}, if3.result_o, res);
        end
    endtask

    vec_t       vecs [8];
    logic [7:0] op_list [5];
    logic       exp_tie [4];
    logic       win [4];
    int         gcyc [4];
    exp_t       ex [NR + 8];

    initial begin
        int ng;
        int free_at;
        logic pref, q0, q1, pend0, pend1, w;
        logic [7:0] po0, pa0, po1, pa1, macc, cur_res, cur_st, cur_opc;
        logic mc, mv, cur_own;
        alu_out_t r;

        op_list[0] = LDA_IMM; op_list[1] = ADC_IMM; op_list[2] = AND_IMM;
        op_list[3] = ORA_IMM; op_list[4] = EOR_IMM;
        vecs[0] = '{1'b0, LDA_IMM, 8'h00, 8'h00, 8'h22};
        vecs[1] = '{1'b0, LDA_IMM, 8'h01, 8'h01, 8'h20};
        vecs[2] = '{1'b1, ADC_IMM, 8'h7F, 8'h80, 8'hE0};
        vecs[3] = '{1'b0, ADC_IMM, 8'h80, 8'h00, 8'h63};
        vecs[4] = '{1'b1, ORA_IMM, 8'hF0, 8'hF0, 8'hE1};
        vecs[5] = '{1'b0, EOR_IMM, 8'hFF, 8'h0F, 8'h61};
        vecs[6] = '{1'b1, ADC_IMM, 8'h01, 8'h11, 8'h20};
        vecs[7] = '{1'b0, LDA_IMM, 8'hFF, 8'hFF, 8'hA0};
`ifdef ALU_SCHED_ROUND_ROBIN_EN
        exp_tie[0] = 1'b0; exp_tie[1] = 1'b1; exp_tie[2] = 1'b0; exp_tie[3] = 1'b1;
`else
        exp_tie[0] = 1'b0; exp_tie[1] = 1'b0; exp_tie[2] = 1'b0; exp_tie[3] = 1'b0;
`endif

        if1.req0_i = 1'b0; if1.req1_i = 1'b0; if1.op0_i = 8'h00; if1.op1_i = 8'h00;
        if1.a0_i = 8'h00; if1.a1_i = 8'h00;
        if3.req0_i = 1'b0; if3.req1_i = 1'b0; if3.op0_i = 8'h00; if3.op1_i = 8'h00;
        if3.a0_i = 8'h00; if3.a1_i = 8'h00;

        // Reset state, then confirm the scheduler idles after release.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        chk("reset3_opc", if3.alu_opcode_o, NOP);
        n_rst = 1'b1;
        repeat (3) tick1();
        chk("post_rst_busy", 8'(if1.busy_o), 8'h00);
        chk("post_rst_en",   8'(if1.alu_enable_o), 8'h00);

        // Both requesters held high for four operations.
        tick1();
        if1.req0_i = 1'b1; if1.op0_i = LDA_IMM; if1.a0_i = 8'h11;
        if1.req1_i = 1'b1; if1.op1_i = LDA_IMM; if1.a1_i = 8'h22;
        ng = 0;
        for (int i = 0; i < 4; i++) begin win[i] = 1'b0; gcyc[i] = 0; end
        for (int t = 1; t <= 30 && ng < 4; t++) begin
            tick1();
            if (if1.gnt0_o && if1.gnt1_o) chk("tie_both_gnt", 8'h01, 8'h00);
            if (if1.gnt0_o || if1.gnt1_o) begin
                win[ng] = if1.gnt1_o; gcyc[ng] = t; ng++;
            end
        end
        if1.req0_i = 1'b0; if1.req1_i = 1'b0;
        chk("tie_count", 8'(ng), 8'd4);
        chk("tie_first_lat", 8'(gcyc[0]), 8'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_win%0d", i), 8'(win[i]), 8'(exp_tie[i]));
        for (int i = 1; i < 4; i++) chk($sformatf("tie_gap%0d", i), 8'(gcyc[i] - gcyc[i-1]), 8'd4);
        repeat (5) tick1();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Randomised traffic against a transaction-level timing model.
        n_rst = 1'b0;
        tick1(); tick1();
        n_rst = 1'b1;
        for (int i = 0; i < NR + 8; i++) ex[i] = '0;
        free_at = 0; pref = 1'b0; macc = 8'h00; mc = 1'b0; mv = 1'b0;
        cur_own = 1'b0; cur_res = 8'h00; cur_st = 8'h00; cur_opc = NOP;
        q0 = 1'b0; q1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        po0 = 8'h00; pa0 = 8'h00; po1 = 8'h00; pa1 = 8'h00;
        for (int c = 0; c < NR; c++) begin
            if (ex[c].set_own) cur_own = ex[c].own;
            if (ex[c].set_res) begin cur_res = ex[c].res; cur_st = ex[c].st; end
            if (ex[c].set_opc) cur_opc = ex[c].opc;
            chk($sformatf("rnd%0d_gnt0", c),  8'(if1.gnt0_o),  8'(ex[c].gnt0));
            chk($sformatf("rnd%0d_gnt1", c),  8'(if1.gnt1_o),  8'(ex[c].gnt1));
            chk($sformatf("rnd%0d_done0", c), 8'(if1.done0_o), 8'(ex[c].done0));
            chk($sformatf("rnd%0d_done1", c), 8'(if1.done1_o), 8'(ex[c].done1));
            chk($sformatf("rnd%0d_busy", c),  8'(if1.busy_o),  8'(ex[c].busy));
            chk($sformatf("rnd%0d_en", c),    8'(if1.alu_enable_o), 8'(ex[c].en));
            chk($sformatf("rnd%0d_owner", c), 8'(if1.owner_o), 8'(cur_own));
            chk($sformatf("rnd%0d_res", c),   if1.result_o, cur_res);
            chk($sformatf("rnd%0d_st", c),    if1.status_o, cur_st);
            chk($sformatf("rnd%0d_opc", c),   if1.alu_opcode_o, cur_opc);
            if (ex[c].en) chk($sformatf("rnd%0d_a", c), if1.alu_a_o, ex[c].a);

            if (if1.gnt0_o) pend0 = 1'b0;
            else if (!pend0) begin
                q0 = ($urandom_range(0, 3) == 0);
                if (q0) begin pend0 = 1'b1; po0 = op_list[$urandom_range(0, 4)]; pa0 = 8'($urandom); end
            end
            if (if1.gnt1_o) pend1 = 1'b0;
            else if (!pend1) begin
                q1 = ($urandom_range(0, 3) == 0);
                if (q1) begin pend1 = 1'b1; po1 = op_list[$urandom_range(0, 4)]; pa1 = 8'($urandom); end
            end
            if1.req0_i = q0; if1.op0_i = po0; if1.a0_i = pa0;
            if1.req1_i = q1; if1.op1_i = po1; if1.a1_i = pa1;

            if (c >= free_at && (q0 || q1)) begin
`ifdef ALU_SCHED_ROUND_ROBIN_EN
                w = (q0 && q1) ? pref : q1;
`else
                w = !q0;
`endif
                pref = !w;
                ex[c+1].gnt0 = !w; ex[c+1].gnt1 = w; ex[c+1].en = 1'b1;
                ex[c+1].set_own = 1'b1; ex[c+1].own = w;
                ex[c+1].set_opc = 1'b1; ex[c+1].opc = w ? po1 : po0; ex[c+1].a = w ? pa1 : pa0;
                for (int k = c + 1; k <= c + 3; k++) ex[k].busy = 1'b1;
                r = alu_ref(w ? po1 : po0, w ? pa1 : pa0, macc, mc, mv);
                macc = r.acc; mc = r.c; mv = r.v;
                ex[c+3].done0 = !w; ex[c+3].done1 = w;
                ex[c+3].set_res = 1'b1; ex[c+3].res = r.res; ex[c+3].st = r.st;
                ex[c+4].set_opc = 1'b1; ex[c+4].opc = NOP;
                free_at = c + 4;
            end
            tick1();
        end
        if1.req0_i = 1'b0; if1.req1_i = 1'b0;
        repeat (8) tick1();

        // Reset while the operation waits on the ALU: dropped without a done.
        tick1();
        if1.req0_i = 1'b1; if1.op0_i = LDA_IMM; if1.a0_i = 8'h55;
        tick1();
        chk("midrst_gnt0", 8'(if1.gnt0_o), 8'h01);
        tick1();
        if1.req0_i = 1'b0;
        n_rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick1();
        chk("midrst_no_done", 8'(if1.done0_o), 8'h00);
        chk("midrst_busy",    8'(if1.busy_o), 8'h00);
        n_rst = 1'b1;
        apply_vec('{1'b1, LDA_IMM, 8'h33, 8'h33, 8'h20}, "after_rst");

        lat3_op(1'b0, LDA_IMM, 8'h42, 8'h00, 8'h42, 8'h20, "lat3_a");
        lat3_op(1'b1, LDA_IMM, 8'h80, 8'h42, 8'h80, 8'hA0, "lat3_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
